// File: rtl/ysyx_24070017_pkg.sv
// Shared definitions for the NPC sequencer: opcodes, FSM state encoding, word width.
package ysyx_24070017_pkg;

  localparam int unsigned ysyx_24070017_WORD_LENGTH = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_EBREAK = 3'b000;

  typedef enum logic [2:0] {
    StFetch,
    StWaitInst,
    StExec,
    StMemReq,
    StMemWait,
    StWb,
    StHalt,
    StError
  } state_e;

  // States that sit on a memory handshake and are subject to the timeout.
  function automatic logic is_wait_state(state_e s);
    return (s == StFetch) || (s == StWaitInst) || (s == StMemReq) || (s == StMemWait);
  endfunction

endpackage

// File: rtl/ysyx_24070017_Reg.sv
// Generic enabled register with synchronous active-high reset.
module ysyx_24070017_Reg #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // Load din when enabled; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24070017_wait_cnt.sv
// Handshake wait counter: counts cycles spent in one waiting state and flags
// the cycle on which the count would reach the limit.
module ysyx_24070017_wait_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WIDTH:0] LimitW = (WIDTH + 1)'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  // A pending state change means the wait was satisfied this cycle.
  assign expired   = inc && !clear && (count_inc == LimitW);

  // Clear on state change, otherwise count while waiting.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ysyx_24070017_seq_ctrl.sv
// Multi-cycle sequencer for the NPC datapath. Owns PC/IR/RF write enables,
// instruction/data memory handshakes, halt/err reporting and instret.
// Optional handshake timeout: define YSYX_24070017_MEM_TIMEOUT_EN.
module ysyx_24070017_seq_ctrl
  import ysyx_24070017_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  output logic        dmem_req_valid,
  output logic        dmem_req_wen,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [63:0] instret,
  output logic        halt,
  output logic        err
);

  logic [2:0]  state_raw;
  state_e      state_q, state_nxt, state_d;
  logic        mem_wen_q, mem_wen_d;
  logic [63:0] instret_q;
  logic        retire;
  logic        timeout;
  logic        unused_cfg;

  assign unused_cfg = (WORD_LENGTH == ysyx_24070017_WORD_LENGTH) ^ (TIMEOUT_CYCLES == 0);

  ysyx_24070017_Reg #(
    .WIDTH     (3),
    .RESET_VAL (StFetch)
  ) u_state_reg (
    .clk  (clk),
    .rst  (rst),
    .din  (state_d),
    .dout (state_raw),
    .wen  (1'b1)
  );

  assign state_q = state_e'(state_raw);

`ifdef YSYX_24070017_MEM_TIMEOUT_EN
  ysyx_24070017_wait_cnt #(
    .WIDTH (8),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_nxt != state_q),
    .inc     (is_wait_state(state_q)),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and output decode; outputs are forced low during reset.
  always_comb begin
    state_nxt      = state_q;
    mem_wen_d      = mem_wen_q;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    rf_we          = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = StWaitInst;
      end
      StWaitInst: begin
        if (imem_rsp_valid) begin
          ir_we     = 1'b1;
          state_nxt = StExec;
        end
      end
      StExec: begin
        case (opcode)
          OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_JAL, OPC_JALR: begin
            pc_we     = 1'b1;
            rf_we     = 1'b1;
            state_nxt = StFetch;
          end
          OPC_BRANCH: begin
            pc_we     = 1'b1;
            state_nxt = StFetch;
          end
          OPC_LOAD: begin
            mem_wen_d = 1'b0;
            state_nxt = StMemReq;
          end
          OPC_STORE: begin
            mem_wen_d = 1'b1;
            state_nxt = StMemReq;
          end
          OPC_SYSTEM: begin
            state_nxt = (funct3 == F3_EBREAK) ? StHalt : StError;
          end
          default: state_nxt = StError;
        endcase
      end
      StMemReq: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nxt = StMemWait;
      end
      StMemWait: begin
        if (dmem_rsp_valid) state_nxt = StWb;
      end
      StWb: begin
        pc_we     = 1'b1;
        rf_we     = !mem_wen_q;
        state_nxt = StFetch;
      end
      StHalt:  state_nxt = StHalt;
      StError: state_nxt = StError;
      default: state_nxt = StError;
    endcase
    state_d = timeout ? StError : state_nxt;
    if (rst) begin
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      ir_we          = 1'b0;
      pc_we          = 1'b0;
      rf_we          = 1'b0;
    end
  end

  // ebreak retires without a PC write.
  assign retire = pc_we || ((state_q == StExec) && (state_d == StHalt));

  // Access direction and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wen_q <= 1'b0;
      instret_q <= '0;
    end else begin
      mem_wen_q <= mem_wen_d;
      if (retire) instret_q <= instret_q + 64'd1;
    end
  end

  assign dmem_req_wen = mem_wen_q;
  assign instret      = instret_q;
  assign halt         = (state_q == StHalt);
  assign err          = (state_q == StError);

endmodule

// File: tb/tb_ysyx_24070017_seq_ctrl.sv
// Self-checking bench for ysyx_24070017_seq_ctrl: per-cycle vector table with a
// scoreboard queue of expected outputs.
module tb_ysyx_24070017_seq_ctrl;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] SYS  = 7'b1110011;
  localparam logic [6:0] ILL  = 7'b0000000;

  // Handshake inputs {imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid}
  localparam logic [3:0] H0    = 4'b0000;
  localparam logic [3:0] HIRDY = 4'b1000;
  localparam logic [3:0] HIRSP = 4'b0100;
  localparam logic [3:0] HDRDY = 4'b0010;
  localparam logic [3:0] HDRSP = 4'b0001;
  // Expected strobes {imem_req_valid, dmem_req_valid, ir_we, pc_we, rf_we}
  localparam logic [4:0] O0    = 5'b00000;
  localparam logic [4:0] OIREQ = 5'b10000;
  localparam logic [4:0] ODREQ = 5'b01000;
  localparam logic [4:0] OIRWE = 5'b00100;
  localparam logic [4:0] OPC   = 5'b00010;
  localparam logic [4:0] ORF   = 5'b00001;
  // Expected status {halt, err}
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] SH = 2'b10;
  localparam logic [1:0] SE = 2'b01;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [3:0]  hs;
    logic [4:0]  strobes;
    logic        wen;
    logic [1:0]  status;
    logic [63:0] instret;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        dmem_req_valid, dmem_req_wen, dmem_req_ready, dmem_rsp_valid;
  logic        ir_we, pc_we, rf_we, halt, err;
  logic [63:0] instret;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_24070017_seq_ctrl #(
    .WORD_LENGTH    (32),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .funct3         (funct3),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_wen   (dmem_req_wen),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .ir_we          (ir_we),
    .pc_we          (pc_we),
    .rf_we          (rf_we),
    .instret        (instret),
    .halt           (halt),
    .err            (err)
  );

  task automatic add(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [3:0] hs, input logic [4:0] st, input logic wen,
                     input logic [1:0] status, input longint unsigned ins);
    vec_t v;
    v.rst = r; v.opc = opc; v.f3 = f3; v.hs = hs; v.strobes = st;
    v.wen = wen; v.status = status; v.instret = ins;
    vecs.push_back(v);
  endtask

  // One fetch + decode of an ALU-class instruction with zero-wait memory.
  task automatic add_alu(input logic [6:0] opc, input longint unsigned ins);
    add(0, ADDI, 3'd0, HIRDY, OIREQ, 0, S0, ins);
    add(0, ADDI, 3'd0, HIRSP, OIRWE, 0, S0, ins);
    add(0, opc,  3'd0, H0,    (opc == BEQ) ? OPC : (OPC | ORF), 0, S0, ins);
  endtask

  task automatic check(input vec_t e);
    logic [4:0] got;
    got = {imem_req_valid, dmem_req_valid, ir_we, pc_we, rf_we};
    checks++;
    if (got !== e.strobes) begin
      errors++;
      $display("FAIL strobes: got %b expected %b (ireq,dreq,ir_we,pc_we,rf_we)", got, e.strobes);
    end
    checks++;
    if (instret !== e.instret) begin
      errors++;
      $display("FAIL instret: got %0d expected %0d", instret, e.instret);
    end
    if (e.strobes[3]) begin
      checks++;
      if (dmem_req_wen !== e.wen) begin
        errors++;
        $display("FAIL dmem_req_wen: got %b expected %b", dmem_req_wen, e.wen);
      end
    end
    if (!e.rst) begin
      checks++;
      if ({halt, err} !== e.status) begin
        errors++;
        $display("FAIL halt_err: got %b expected %b", {halt, err}, e.status);
      end
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;

    // Reset, then addi with zero-wait memory.
    add(1, ILL, 3'd0, H0, O0, 0, S0, 0);
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 0);
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 0);
    add(0, ADDI, 3'd0, H0, OPC | ORF, 0, S0, 0);
    add(0, ILL, 3'd0, H0, OIREQ, 0, S0, 1);
    // lw: request accepted after 3 wait cycles, response 2 cycles later.
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 1);
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 1);
    add(0, LW,  3'd2, H0, O0, 0, S0, 1);
    add(0, ILL, 3'd0, H0, ODREQ, 0, S0, 1);
    add(0, ILL, 3'd0, H0, ODREQ, 0, S0, 1);
    add(0, ILL, 3'd0, H0, ODREQ, 0, S0, 1);
    add(0, ILL, 3'd0, HDRDY, ODREQ, 0, S0, 1);
    add(0, ILL, 3'd0, H0, O0, 0, S0, 1);
    add(0, ILL, 3'd0, HDRSP, O0, 0, S0, 1);
    add(0, ILL, 3'd0, H0, OPC | ORF, 0, S0, 1);
    // sw, with a stray data response while waiting for the instruction.
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 2);
    add(0, ILL, 3'd0, HDRSP, O0, 0, S0, 2);
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 2);
    add(0, SW,  3'd2, H0, O0, 0, S0, 2);
    add(0, ILL, 3'd0, HDRDY, ODREQ, 1, S0, 2);
    add(0, ILL, 3'd0, HDRSP, O0, 0, S0, 2);
    add(0, ILL, 3'd0, H0, OPC, 0, S0, 2);
    // beq
    add_alu(BEQ, 3);
    // Reset with ready high: no request during the reset cycle.
    add(1, ILL, 3'd0, HIRDY, O0, 0, S0, 4);
    for (int k = 0; k < 5; k++) add_alu(ADDI, k);
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 5);
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 5);
    add(0, SYS, 3'd0, H0, O0, 0, S0, 5);
    add(0, ILL, 3'd0, HIRDY | HIRSP | HDRSP, O0, 0, SH, 6);
    add(0, ADDI, 3'd0, HIRDY, O0, 0, SH, 6);
    add(1, ILL, 3'd0, H0, O0, 0, S0, 6);
    add(0, ILL, 3'd0, H0, OIREQ, 0, S0, 0);
    // Illegal opcode.
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 0);
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 0);
    add(0, ILL, 3'd0, H0, O0, 0, S0, 0);
    add(0, ADDI, 3'd0, HIRDY | HIRSP, O0, 0, SE, 0);
    add(0, ADDI, 3'd0, H0, O0, 0, SE, 0);
    add(1, ILL, 3'd0, H0, O0, 0, S0, 0);
    // Reset in MEM_WAIT, then late data response is ignored.
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 0);
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 0);
    add(0, LW,  3'd2, H0, O0, 0, S0, 0);
    add(0, ILL, 3'd0, HDRDY, ODREQ, 0, S0, 0);
    add(0, ILL, 3'd0, H0, O0, 0, S0, 0);
    add(1, ILL, 3'd0, HDRSP, O0, 0, S0, 0);
    add(0, ILL, 3'd0, HDRSP, OIREQ, 0, S0, 0);
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 0);
    add(0, ILL, 3'd0, H0, O0, 0, S0, 0);
    // SYSTEM with non-ebreak funct3 is an error.
    add(0, ILL, 3'd0, HIRSP, OIRWE, 0, S0, 0);
    add(0, SYS, 3'd1, H0, O0, 0, S0, 0);
    add(0, ILL, 3'd0, H0, O0, 0, SE, 0);
`ifdef YSYX_24070017_MEM_TIMEOUT_EN
    // Instruction response never arrives: ERROR after 4 cycles in WAIT_INST.
    add(1, ILL, 3'd0, H0, O0, 0, S0, 0);
    add(0, ILL, 3'd0, HIRDY, OIREQ, 0, S0, 0);
    for (int k = 0; k < 4; k++) add(0, ILL, 3'd0, H0, O0, 0, S0, 0);
    add(0, ILL, 3'd0, H0, O0, 0, SE, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      opcode         = vecs[i].opc;
      funct3         = vecs[i].f3;
      imem_req_ready = vecs[i].hs[3];
      imem_rsp_valid = vecs[i].hs[2];
      dmem_req_ready = vecs[i].hs[1];
      dmem_rsp_valid = vecs[i].hs[0];
      exp_q.push_back(vecs[i]);
      #3;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        check(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
